program_counter: RTL and testbench

- Architectural program-counter register for the RV32IM single-cycle CPU.
- Each clock it latches the next-PC value, already selected upstream by the next-PC mux (PC+4, branch or jump target), and presents it as the current fetch address.
- Sits between the next-PC mux and the instruction memory address port.
- Also supplies PC+4 and an instruction-address-misaligned flag to the rest of the datapath.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/program_counter.sv | 25 ++
 tb/tb_program_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants for the RV32IM single-cycle CPU.
package cpu_pkg;
    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam int              INSTR_BYTES  = 4;
endpackage

// File: rtl/program_counter.sv
// Architectural PC register: latches the already-muxed next PC every edge and
// exports the fetch address, its sequential successor and an alignment flag.
module program_counter #(
    parameter int                       XLEN       = cpu_pkg::XLEN,
    parameter logic [cpu_pkg::XLEN-1:0] RESET_ADDR = cpu_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_addr,
    output logic [XLEN-1:0] curr_addr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);
    import cpu_pkg::*;

    // No enable: the upstream mux re-presents the current PC when it wants to hold.
    always_ff @(posedge clk) begin
        if (rst) curr_addr <= XLEN'(RESET_ADDR);
        else     curr_addr <= next_addr;
    end

    // Wraps modulo 2^XLEN; carry-out is intentionally dropped.
    assign pc_plus4   = curr_addr + XLEN'(INSTR_BYTES);
    assign misaligned = |curr_addr[1:0];
endmodule

// File: tb/tb_program_counter.sv
// Directed scoreboard bench for program_counter.
module tb_program_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_addr = '0;
    logic [31:0] curr_addr, pc_plus4;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] plus4;
        logic        mis;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model_pc;

    program_counter dut (
        .clk(clk), .rst(rst), .next_addr(next_addr),
        .curr_addr(curr_addr), .pc_plus4(pc_plus4), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expected post-edge state, then compare.
    task automatic step(input string tag, input logic r, input logic [31:0] na);
        exp_t e;
        rst       = r;
        next_addr = na;
        model_pc  = r ? 32'h0000_0000 : na;
        e.addr  = model_pc;
        e.plus4 = model_pc + 32'd4;
        e.mis   = (model_pc[1:0] != 2'b00);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".curr"},  curr_addr,           e.addr);
            check({tag, ".plus4"}, pc_plus4,            e.plus4);
            check({tag, ".mis"},   {31'd0, misaligned}, {31'd0, e.mis});
        end
    endtask

    initial begin
        step("reset",      1'b1, 32'h0000_0000);
        step("seq4",       1'b0, 32'h0000_0004);
        step("seq8",       1'b0, 32'h0000_0008);
        step("jump20",     1'b0, 32'h0000_0020);
        step("jump24",     1'b0, 32'h0000_0024);
        step("rst_mid",    1'b1, 32'h0000_0024);
        step("rst_rel",    1'b0, 32'h0000_0004);
        step("back_jump",  1'b0, 32'h0000_0100);
        step("back_jump2", 1'b0, 32'h0000_0010);

        // Reset raised between edges must not disturb the register.
        rst = 1'b1;
        #2;
        check("rst_async.curr", curr_addr, model_pc);
        step("rst_prio",   1'b1, 32'hDEAD_BEEF);
        step("mis22",      1'b0, 32'h0000_0022);
        step("wrap",       1'b0, 32'hFFFF_FFFC);
        step("mis_top",    1'b0, 32'hFFFF_FFFF);
        step("mis_one",    1'b0, 32'h0000_0001);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
